vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Shares one synchronous single-port text/attribute RAM between two requesters: the display fetch path (feeds the character generator) and a host port (CPU/loader reads and writes).
- Sits between the VGA timing/char generator pipeline and the video RAM, in the pixel clock domain.
- Display fetches have absolute priority because they carry a scanline deadline. The host uses free slots, and a sticky flag reports host starvation.

Parameters:
- AW, 12, RAM word address width.
- DW, 16, RAM data width (char code + colour attribute).
- STARVE_MAX, 64, host pending-cycle count at which host_starved_o sets (1..255).

Ports:
- clk_i  in  1  pixel clock
- rstn_i  in  1  asynchronous active-low reset
- disp_req_i  in  1  display fetch request, single-cycle, may assert every cycle
- disp_addr_i  in  AW  display fetch address, valid with disp_req_i
- disp_data_o  out  DW  fetched word
- disp_valid_o  out  1  disp_data_o valid pulse
- host_req_i  in  1  host request level, held until ack
- host_we_i  in  1  1=write, 0=read, stable while req high
- host_addr_i  in  AW  host address, stable while req high
- host_wdata_i  in  DW  host write data, stable while req high
- host_ack_o  out  1  one-cycle completion pulse
- host_rdata_o  out  DW  host read data, valid with host_ack_o, held until next read ack
- clr_starved_i  in  1  clears host_starved_o
- host_starved_o  out  1  sticky starvation flag
- mem_en_o  out  1  RAM enable
- mem_we_o  out  1  RAM write enable
- mem_addr_o  out  AW  RAM address
- mem_wdata_o  out  DW  RAM write data
- mem_rdata_i  in  DW  RAM read data, 1-cycle latency after mem_en_o & !mem_we_o

Behaviour:
- Reset (async assert, sync release): all outputs 0, host FSM IDLE, pipeline tags cleared, starve counter 0. Any in-flight transaction is discarded with no ack or valid.
- Slot arbitration happens each cycle T on registered-free inputs. The winner drives the registered mem_* outputs at T+1. At most one RAM access per cycle.
  - disp_req_i=1 at T: display wins unconditionally. mem_en_o=1, mem_we_o=0, mem_addr_o=disp_addr_i at T+1.
  - Otherwise, if host FSM is PEND: host wins. mem_we_o=host_we_i, mem_wdata_o=host_wdata_i.
  - No winner: mem_en_o=0, mem_we_o=0. Address and wdata hold their last values.
- Display latency: req at T gives disp_valid_o=1 and disp_data_o=captured mem_rdata_i at T+3. Fully pipelined, so back-to-back requests produce back-to-back valids in order.
- Host FSM states: IDLE, PEND, ISSUED, RDWAIT, ACK.
  - IDLE: host_req_i=1 moves to PEND in the same cycle. Arbitration evaluates PEND combinationally from host_req_i when in IDLE, so a request with no display request present is granted at the first cycle.
  - PEND: granted at T goes to ISSUED (mem access at T+1).
  - ISSUED: write goes to ACK. Read goes to RDWAIT, which captures mem_rdata_i into host_rdata_o, then goes to ACK.
  - ACK: host_ack_o=1 for exactly one cycle, then IDLE. host_req_i still high in the cycle after ACK is a new transaction.
  - Resulting latency with a free slot: write ack at T+2, read ack at T+3.
- Separate read-owner tags (a 2-deep shift of {disp, host}) steer mem_rdata_i. Host and display data never cross.
- Starvation:
  - An 8-bit counter increments each cycle the FSM is PEND and is not granted. It saturates at 255 and clears on grant or IDLE.
  - host_starved_o sets when count == STARVE_MAX and stays set until clr_starved_i=1.
  - Set and clear in the same cycle: set wins.
  - Starvation never overrides display priority; a continuous disp_req_i stalls the host indefinitely.
- host_req_i dropped while PEND is a protocol violation. The FSM returns to IDLE without a RAM access or ack.

Test Plan:
- Display read: preload addr 0x010=0xA55A; disp_req_i at cycle 5 -> mem_en_o=1, addr 0x010 at 6; disp_valid_o=1, data 0xA55A at 8.
- Host write, idle bus: write 0x0123 to 0x020 at cycle 10 -> mem_we_o=1 at 11; host_ack_o pulse at 12. A follow-up host read of 0x020 returns 0x0123.
- Collision: host read 0x030 and disp_req_i (0x031) at cycle 20, disp_req_i deasserted at 21 -> display at mem cycle 21, host at 22. disp_valid_o at 23, host_ack_o at 24, each with the correct word.
- Back-to-back display: disp_req_i for 8 cycles on addresses 0x100..0x107 -> 8 consecutive valids in order. A pending host request waits and is issued the cycle after the burst ends.
- Starvation: STARVE_MAX=4, host pending under continuous disp_req_i -> host_starved_o rises after 4 ungranted cycles. It persists after the grant and clears one cycle after clr_starved_i.
- Reset mid-read: rstn_i low in RDWAIT -> all outputs 0 immediately. No ack after release; the FSM starts in IDLE.

Source files
------------

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display fetches have absolute priority over a host port.
// A fixed three-cycle pipeline returns display data; a host FSM issues one access at a time and flags starvation.
module vram_arbiter #(
    parameter int AW         = 12,
    parameter int DW         = 16,
    parameter int STARVE_MAX = 64
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          disp_req_i,
    input  logic [AW-1:0] disp_addr_i,
    output logic [DW-1:0] disp_data_o,
    output logic          disp_valid_o,
    input  logic          host_req_i,
    input  logic          host_we_i,
    input  logic [AW-1:0] host_addr_i,
    input  logic [DW-1:0] host_wdata_i,
    output logic          host_ack_o,
    output logic [DW-1:0] host_rdata_o,
    input  logic          clr_starved_i,
    output logic          host_starved_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    localparam logic [7:0] SMAX = 8'(STARVE_MAX);

    typedef enum logic [2:0] {
        IDLE,
        PEND,
        ISSUED,
        RDWAIT,
        ACK
    } hstate_t;

    hstate_t    state;
    hstate_t    state_nx;
    logic       host_pend;
    logic       host_win;
    logic [1:0] tag1;
    logic [1:0] tag2;
    logic [7:0] cnt;
    logic [7:0] cnt_nx;

    // An IDLE request competes in the same cycle it arrives.
    assign host_pend  = host_req_i && (state == IDLE || state == PEND);
    assign host_win   = host_pend && !disp_req_i;
    assign host_ack_o = (state == ACK);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (host_req_i)
                    state_nx = host_win ? ISSUED : PEND;
            end
            PEND: begin
                if (!host_req_i)
                    state_nx = IDLE;
                else if (host_win)
                    state_nx = ISSUED;
            end
            ISSUED:  state_nx = mem_we_o ? ACK : RDWAIT;
            RDWAIT:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx = 8'd0;
        if (host_pend && !host_win)
            cnt_nx = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state          <= IDLE;
            cnt            <= 8'd0;
            host_starved_o <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (host_pend && !host_win && cnt_nx == SMAX)
                host_starved_o <= 1'b1;
            else if (clr_starved_i)
                host_starved_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mem_en_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
        end else begin
            mem_en_o <= disp_req_i || host_win;
            mem_we_o <= host_win && host_we_i;
            if (disp_req_i) begin
                mem_addr_o <= disp_addr_i;
            end else if (host_win) begin
                mem_addr_o  <= host_addr_i;
                mem_wdata_o <= host_wdata_i;
            end
        end
    end

    // Read-owner tags {disp, host} follow each read to its data cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tag1         <= 2'b00;
            tag2         <= 2'b00;
            disp_valid_o <= 1'b0;
            disp_data_o  <= '0;
            host_rdata_o <= '0;
        end else begin
            tag1         <= {disp_req_i, host_win && !host_we_i};
            tag2         <= tag1;
            disp_valid_o <= tag2[1];
            if (tag2[1])
                disp_data_o <= mem_rdata_i;
            if (tag2[0])
                host_rdata_o <= mem_rdata_i;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural one-cycle-latency RAM.
// Each task drives a scenario and checks hand-computed cycle-exact results.
module tb_vram_arbiter;

    logic        clk;
    logic        rstn;
    logic        disp_req;
    logic [11:0] disp_addr;
    logic [15:0] disp_data;
    logic        disp_valid;
    logic        host_req;
    logic        host_we;
    logic [11:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_ack;
    logic [15:0] host_rdata;
    logic        clr;
    logic        starved;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [0:4095];

    int pass  = 0;
    int total = 0;

    vram_arbiter #(
        .AW(12),
        .DW(16),
        .STARVE_MAX(4)
    ) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .disp_req_i    (disp_req),
        .disp_addr_i   (disp_addr),
        .disp_data_o   (disp_data),
        .disp_valid_o  (disp_valid),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_ack_o    (host_ack),
        .host_rdata_o  (host_rdata),
        .clr_starved_i (clr),
        .host_starved_o(starved),
        .mem_en_o      (mem_en),
        .mem_we_o      (mem_we),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we)
                ram[mem_addr] <= mem_wdata;
            else
                mem_rdata <= ram[mem_addr];
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [11:0] a, input logic [15:0] d);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        step();
        step();
        host_req = 1'b0;
        step();
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, host_ack, host_rdata,
             disp_valid, disp_data, starved} !== 65'd0)
            $display("FAIL reset_outputs got en=%b ack=%b valid=%b starved=%b exp all 0",
                     mem_en, host_ack, disp_valid, starved);
        else
            pass++;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        step();
        total++;
        if ({mem_en, host_ack, disp_valid, starved} !== 4'd0)
            $display("FAIL reset_release got %b exp 0000",
                     {mem_en, host_ack, disp_valid, starved});
        else
            pass++;
    endtask

    task automatic test_host_write;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 12'h020;
        host_wdata = 16'h0123;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, host_ack} !== {1'b1, 1'b1, 12'h020, 16'h0123, 1'b0})
            $display("FAIL hw_issue got en=%b we=%b addr=%h wd=%h ack=%b exp 1 1 020 0123 0",
                     mem_en, mem_we, mem_addr, mem_wdata, host_ack);
        else
            pass++;
        step();
        total++;
        if ({host_ack, mem_en} !== 2'b10)
            $display("FAIL hw_ack got ack=%b en=%b exp 1 0", host_ack, mem_en);
        else
            pass++;
        host_req = 1'b0;
        step();
        total++;
        if (host_ack !== 1'b0)
            $display("FAIL hw_ack_pulse got %b exp 0", host_ack);
        else
            pass++;
        host_req = 1'b1;
        host_we  = 1'b0;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h020})
            $display("FAIL hr_issue got en=%b we=%b addr=%h exp 1 0 020", mem_en, mem_we, mem_addr);
        else
            pass++;
        step();
        total++;
        if (host_ack !== 1'b0)
            $display("FAIL hr_early_ack got %b exp 0", host_ack);
        else
            pass++;
        step();
        total++;
        if ({host_ack, host_rdata} !== {1'b1, 16'h0123})
            $display("FAIL hr_data got ack=%b data=%h exp 1 0123", host_ack, host_rdata);
        else
            pass++;
        host_req = 1'b0;
        step();
        total++;
        if ({host_ack, host_rdata} !== {1'b0, 16'h0123})
            $display("FAIL hr_hold got ack=%b data=%h exp 0 0123", host_ack, host_rdata);
        else
            pass++;
    endtask

    task automatic preload;
        host_write(12'h010, 16'hA55A);
        host_write(12'h030, 16'h3030);
        host_write(12'h031, 16'h3131);
        host_write(12'h040, 16'h4444);
        host_write(12'h050, 16'h5555);
        for (int k = 0; k < 8; k++)
            host_write(12'h100 + 12'(k), 16'h1000 + 16'(k) * 16'h0111);
    endtask

    task automatic test_disp_read;
        disp_req  = 1'b1;
        disp_addr = 12'h010;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h010})
            $display("FAIL dr_issue got en=%b we=%b addr=%h exp 1 0 010", mem_en, mem_we, mem_addr);
        else
            pass++;
        disp_req = 1'b0;
        step();
        total++;
        if (disp_valid !== 1'b0)
            $display("FAIL dr_early_valid got %b exp 0", disp_valid);
        else
            pass++;
        step();
        total++;
        if ({disp_valid, disp_data} !== {1'b1, 16'hA55A})
            $display("FAIL dr_data got valid=%b data=%h exp 1 a55a", disp_valid, disp_data);
        else
            pass++;
        step();
        total++;
        if (disp_valid !== 1'b0)
            $display("FAIL dr_valid_pulse got %b exp 0", disp_valid);
        else
            pass++;
    endtask

    task automatic test_collision;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 12'h030;
        disp_req  = 1'b1;
        disp_addr = 12'h031;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h031})
            $display("FAIL col_disp_slot got en=%b we=%b addr=%h exp 1 0 031", mem_en, mem_we, mem_addr);
        else
            pass++;
        disp_req = 1'b0;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h030})
            $display("FAIL col_host_slot got en=%b we=%b addr=%h exp 1 0 030", mem_en, mem_we, mem_addr);
        else
            pass++;
        step();
        total++;
        if ({disp_valid, disp_data, host_ack} !== {1'b1, 16'h3131, 1'b0})
            $display("FAIL col_disp_data got valid=%b data=%h ack=%b exp 1 3131 0",
                     disp_valid, disp_data, host_ack);
        else
            pass++;
        step();
        total++;
        if ({host_ack, host_rdata, disp_valid} !== {1'b1, 16'h3030, 1'b0})
            $display("FAIL col_host_data got ack=%b data=%h valid=%b exp 1 3030 0",
                     host_ack, host_rdata, disp_valid);
        else
            pass++;
        host_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        logic [15:0] exp_d;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 12'h200;
        host_wdata = 16'hBEEF;
        for (int i = 0; i < 12; i++) begin
            disp_req  = (i < 8);
            disp_addr = 12'h100 + 12'(i);
            step();
            if (i < 8) begin
                total++;
                if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h100 + 12'(i)})
                    $display("FAIL b2b_slot%0d got en=%b we=%b addr=%h exp 1 0 %h",
                             i, mem_en, mem_we, mem_addr, 12'h100 + 12'(i));
                else
                    pass++;
            end else if (i == 8) begin
                total++;
                if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 12'h200, 16'hBEEF})
                    $display("FAIL b2b_host_slot got en=%b we=%b addr=%h wd=%h exp 1 1 200 beef",
                             mem_en, mem_we, mem_addr, mem_wdata);
                else
                    pass++;
            end
            if (i >= 2 && i < 10) begin
                exp_d = 16'h1000 + 16'(i - 2) * 16'h0111;
                total++;
                if ({disp_valid, disp_data} !== {1'b1, exp_d})
                    $display("FAIL b2b_valid%0d got valid=%b data=%h exp 1 %h",
                             i, disp_valid, disp_data, exp_d);
                else
                    pass++;
            end else begin
                total++;
                if (disp_valid !== 1'b0)
                    $display("FAIL b2b_novalid%0d got %b exp 0", i, disp_valid);
                else
                    pass++;
            end
            total++;
            if (host_ack !== (i == 9))
                $display("FAIL b2b_ack%0d got %b exp %b", i, host_ack, (i == 9));
            else
                pass++;
            if (i == 9)
                host_req = 1'b0;
        end
    endtask

    task automatic test_drop;
        disp_req   = 1'b1;
        disp_addr  = 12'h000;
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 12'h060;
        host_wdata = 16'h6666;
        step();
        disp_req = 1'b0;
        host_req = 1'b0;
        step();
        total++;
        if (mem_en !== 1'b0)
            $display("FAIL drop_no_access got en=%b addr=%h exp 0", mem_en, mem_addr);
        else
            pass++;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({host_ack, mem_en} !== 2'b00)
                $display("FAIL drop_no_ack%0d got ack=%b en=%b exp 0 0", i, host_ack, mem_en);
            else
                pass++;
        end
    endtask

    task automatic test_starvation;
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (starved !== 1'b0)
            $display("FAIL st_cleared got %b exp 0", starved);
        else
            pass++;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 12'h040;
        disp_req  = 1'b1;
        disp_addr = 12'h000;
        for (int i = 1; i <= 3; i++) begin
            step();
            total++;
            if (starved !== 1'b0)
                $display("FAIL st_early%0d got %b exp 0", i, starved);
            else
                pass++;
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (starved !== 1'b1)
            $display("FAIL st_set_wins got %b exp 1", starved);
        else
            pass++;
        step();
        total++;
        if ({starved, mem_addr} !== {1'b1, 12'h000})
            $display("FAIL st_disp_priority got starved=%b addr=%h exp 1 000", starved, mem_addr);
        else
            pass++;
        disp_req = 1'b0;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h040})
            $display("FAIL st_grant got en=%b we=%b addr=%h exp 1 0 040", mem_en, mem_we, mem_addr);
        else
            pass++;
        step();
        step();
        total++;
        if ({host_ack, host_rdata, starved} !== {1'b1, 16'h4444, 1'b1})
            $display("FAIL st_ack got ack=%b data=%h starved=%b exp 1 4444 1",
                     host_ack, host_rdata, starved);
        else
            pass++;
        host_req = 1'b0;
        clr      = 1'b1;
        step();
        clr = 1'b0;
        total++;
        if (starved !== 1'b0)
            $display("FAIL st_clear got %b exp 0", starved);
        else
            pass++;
    endtask

    task automatic test_reset_mid_read;
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 12'h050;
        step();
        step();
        rstn     = 1'b0;
        host_req = 1'b0;
        #1;
        total++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, host_ack, host_rdata,
             disp_valid, disp_data, starved} !== 65'd0)
            $display("FAIL rst_mid_outputs got addr=%h rdata=%h ddata=%h ack=%b exp all 0",
                     mem_addr, host_rdata, disp_data, host_ack);
        else
            pass++;
        step();
        step();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({host_ack, host_rdata} !== {1'b0, 16'h0000})
                $display("FAIL rst_no_ack%0d got ack=%b data=%h exp 0 0000", i, host_ack, host_rdata);
            else
                pass++;
        end
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 12'h051;
        host_wdata = 16'h0777;
        step();
        total++;
        if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 12'h051})
            $display("FAIL rst_idle_grant got en=%b we=%b addr=%h exp 1 1 051", mem_en, mem_we, mem_addr);
        else
            pass++;
        step();
        total++;
        if (host_ack !== 1'b1)
            $display("FAIL rst_new_ack got %b exp 1", host_ack);
        else
            pass++;
        host_req = 1'b0;
        step();
    endtask

    initial begin
        rstn       = 1'b0;
        disp_req   = 1'b0;
        disp_addr  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        clr        = 1'b0;
        test_reset();
        test_host_write();
        preload();
        test_disp_read();
        test_collision();
        test_back_to_back();
        test_drop();
        test_starvation();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
